// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: fetch-stage state encoding and fetch constants.
package rv_pipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// registers each response into the IF/ID-facing fetch_* outputs.
module if_fetch_unit #(
    parameter int            N         = 32,
    parameter logic [N-1:0]  RESET_PC  = '0,
    parameter logic [N-1:0]  NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    output logic         fetch_valid,
    output logic [N-1:0] fetch_pc,
    output logic [N-1:0] fetch_instr,
    output logic         flush_out
);
    import rv_pipe_pkg::*;

    // state | meaning
    // IDLE  | first cycle after reset, nothing issued yet
    // REQ   | request presented at pc_q, waiting for req_ready
    // WAIT  | request accepted, waiting for its response
    // HOLD  | response parked in hold buffer while decode stalls
    // DROP  | redirected with a request in flight; discard its response

    localparam logic [N-1:0] PC_INC  = N'(PC_STEP);
    localparam logic [N-1:0] PC_MASK = {{(N-2){1'b1}}, 2'b00};

    fetch_state_t state;
    logic [N-1:0] pc_q;
    logic [N-1:0] req_pc;
    logic [N-1:0] hold_pc;
    logic [N-1:0] hold_instr;
    logic         handshake;

    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign handshake      = imem_req_valid & imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_pc      <= '0;
            hold_pc     <= '0;
            hold_instr  <= NOP_INSTR;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= NOP_INSTR;
            flush_out   <= 1'b0;
        end else begin
            flush_out <= 1'b0;
            if (redirect_valid && state != ST_IDLE) begin
                // Redirect beats stall: the IF/ID slot is squashed regardless.
                flush_out   <= 1'b1;
                pc_q        <= redirect_pc & PC_MASK;
                fetch_valid <= 1'b0;
                fetch_instr <= NOP_INSTR;
                hold_pc     <= '0;
                hold_instr  <= NOP_INSTR;
                case (state)
                    ST_WAIT, ST_DROP: state <= imem_rsp_valid ? ST_REQ : ST_DROP;
                    ST_REQ:           state <= handshake ? ST_DROP : ST_REQ;
                    default:          state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_REQ;
                        if (!stall) begin
                            fetch_valid <= 1'b0;
                            fetch_instr <= NOP_INSTR;
                        end
                    end
                    ST_REQ: begin
                        if (handshake) begin
                            req_pc <= pc_q;
                            pc_q   <= pc_q + PC_INC;
                            state  <= ST_WAIT;
                        end
                        if (!stall) begin
                            fetch_valid <= 1'b0;
                            fetch_instr <= NOP_INSTR;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (stall) begin
                                hold_pc    <= req_pc;
                                hold_instr <= imem_rsp_data;
                                state      <= ST_HOLD;
                            end else begin
                                fetch_valid <= 1'b1;
                                fetch_pc    <= req_pc;
                                fetch_instr <= imem_rsp_data;
                                state       <= ST_REQ;
                            end
                        end else if (!stall) begin
                            fetch_valid <= 1'b0;
                            fetch_instr <= NOP_INSTR;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            fetch_valid <= 1'b1;
                            fetch_pc    <= hold_pc;
                            fetch_instr <= hold_instr;
                            state       <= ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (imem_rsp_valid) begin
                            state <= ST_REQ;
                        end
                        if (!stall) begin
                            fetch_valid <= 1'b0;
                            fetch_instr <= NOP_INSTR;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, reset corner case, then
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        flush_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .flush_out      (flush_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rqv, input logic [31:0] e_addr,
                           input logic e_fv, input logic [31:0] e_fpc,
                           input logic [31:0] e_fi, input logic e_fl);
        chk({tag, " req_valid"},   32'(imem_req_valid), 32'(e_rqv));
        chk({tag, " req_addr"},    imem_req_addr, e_addr);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        chk({tag, " fetch_pc"},    fetch_pc, e_fpc);
        chk({tag, " fetch_instr"}, fetch_instr, e_fi);
        chk({tag, " flush_out"},   32'(flush_out), 32'(e_fl));
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_started, m_busy, m_discard, m_buffered, m_fv, m_flush;
    logic [31:0] m_pc, m_req_addr, m_buf_pc, m_buf_instr, m_fpc, m_fi;

    function automatic logic m_req_valid();
        return m_started && !m_busy && !m_buffered;
    endfunction

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_discard = 0; m_buffered = 0;
        m_fv = 0; m_flush = 0; m_pc = 32'h0; m_req_addr = 32'h0;
        m_buf_pc = 0; m_buf_instr = NOP; m_fpc = 0; m_fi = NOP;
    endtask

    task automatic model_step();
        logic rv, hs, load;
        rv = m_started && redirect_valid;
        hs = m_req_valid() && imem_req_ready;
        load = 0;
        m_flush = rv;
        if (!m_started) begin
            m_started = 1;
        end else if (rv) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_fv = 0; m_fi = NOP; m_buffered = 0;
            if (m_busy) begin
                if (imem_rsp_valid) m_busy = 0;
                else m_discard = 1;
            end else if (hs) begin
                m_busy = 1; m_discard = 1;
            end
        end else begin
            if (m_busy && imem_rsp_valid) begin
                m_busy = 0;
                if (!m_discard) begin
                    if (stall) begin
                        m_buffered = 1; m_buf_pc = m_req_addr; m_buf_instr = imem_rsp_data;
                    end else begin
                        m_fv = 1; m_fpc = m_req_addr; m_fi = imem_rsp_data; load = 1;
                    end
                end
            end else if (m_buffered && !stall) begin
                m_fv = 1; m_fpc = m_buf_pc; m_fi = m_buf_instr; m_buffered = 0; load = 1;
            end
            if (hs) begin
                m_req_addr = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_discard = 0;
            end
            if (!stall && !load) begin
                m_fv = 0; m_fi = NOP;
            end
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        stall, rv;
        logic [31:0] rpc;
        logic        rdy, rspv;
        logic [31:0] data;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_fpc, e_fi;
        logic        e_fl;
    } vec_t;

    vec_t tbl[21];

    task automatic drive_idle();
        stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    endtask

    initial begin
        logic        mem_pending;
        int          mem_cnt;
        logic        hs;

        //           stall rv rpc            rdy rspv data           rqv addr          fv fpc           fi            fl
        tbl[0]  = '{0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        NOP,          0};
        tbl[1]  = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,         0, 32'h0,        NOP,          0};
        tbl[2]  = '{0, 0, 32'h0,          0, 1, 32'hA000_0000,  0, 32'h4,         0, 32'h0,        NOP,          0};
        tbl[3]  = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,         1, 32'h0,        32'hA000_0000, 0};
        tbl[4]  = '{0, 0, 32'h0,          0, 1, 32'hA000_0004,  0, 32'h8,         0, 32'h0,        NOP,          0};
        tbl[5]  = '{1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,         1, 32'h4,        32'hA000_0004, 0};
        tbl[6]  = '{1, 0, 32'h0,          0, 1, 32'hA000_0008,  0, 32'hC,         1, 32'h4,        32'hA000_0004, 0};
        tbl[7]  = '{1, 0, 32'h0,          1, 0, 32'h0,          0, 32'hC,         1, 32'h4,        32'hA000_0004, 0};
        tbl[8]  = '{0, 0, 32'h0,          1, 0, 32'h0,          0, 32'hC,         1, 32'h4,        32'hA000_0004, 0};
        tbl[9]  = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hC,         1, 32'h8,        32'hA000_0008, 0};
        tbl[10] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hC,         0, 32'h8,        NOP,          0};
        tbl[11] = '{0, 1, 32'h103,        0, 0, 32'h0,          0, 32'h10,        0, 32'h8,        NOP,          0};
        tbl[12] = '{0, 0, 32'h0,          0, 1, 32'hA000_000C,  0, 32'h100,       0, 32'h8,        NOP,          1};
        tbl[13] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,       0, 32'h8,        NOP,          0};
        tbl[14] = '{1, 0, 32'h0,          0, 1, 32'hA000_0100,  0, 32'h104,       0, 32'h8,        NOP,          0};
        tbl[15] = '{1, 1, 32'h200,        0, 0, 32'h0,          0, 32'h104,       0, 32'h8,        NOP,          0};
        tbl[16] = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h200,       0, 32'h8,        NOP,          1};
        tbl[17] = '{0, 1, 32'hFFFF_FFFE,  0, 0, 32'h0,          1, 32'h200,       0, 32'h8,        NOP,          0};
        tbl[18] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h8,        NOP,          1};
        tbl[19] = '{0, 0, 32'h0,          0, 1, 32'h1234_5678,  0, 32'h0,         0, 32'h8,        NOP,          0};
        tbl[20] = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC, 32'h1234_5678, 0};

        rst_n = 0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 32'h0, 0, 32'h0, NOP, 0);
        rst_n = 1;

        for (int i = 0; i < 21; i++) begin
            stall = tbl[i].stall; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rspv; imem_rsp_data = tbl[i].data;
            chk_all($sformatf("row%0d", i), tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_fv,
                    tbl[i].e_fpc, tbl[i].e_fi, tbl[i].e_fl);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a WAIT
        drive_idle();
        imem_req_ready = 1;
        @(posedge clk);
        #2 rst_n = 0;
        imem_req_ready = 0;
        #1 chk_all("async_rst", 0, 32'h0, 0, 32'h0, NOP, 0);
        @(negedge clk);
        rst_n = 1;
        chk("post_rst c0 req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("post_rst c1 req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst c1 req_addr", imem_req_addr, 32'h0);

        // Randomized traffic against the reference model
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        mem_pending = 0;
        mem_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            chk_all($sformatf("rnd%0d", c), m_req_valid(), m_pc, m_fv, m_fpc, m_fi, m_flush);
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            imem_req_ready = ($urandom_range(0, 9) < 6);
            if (mem_pending && mem_cnt == 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = $urandom;
            end else if (!mem_pending) begin
                imem_rsp_valid = ($urandom_range(0, 9) == 0);
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = 0;
                imem_rsp_data  = $urandom;
            end
            @(posedge clk);
            hs = m_req_valid() && imem_req_ready;
            model_step();
            if (mem_pending) begin
                if (mem_cnt == 0) mem_pending = 0;
                else mem_cnt--;
            end
            if (hs) begin
                mem_pending = 1;
                mem_cnt = $urandom_range(0, 2);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
